sr_cmd_conditioner: RTL
=======================

Name: sr_cmd_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the SR flip-flop and drives its S and R inputs. It takes two raw, asynchronous, bouncy command lines (set button, clear button) and synchronises and debounces each one. It then converts each qualified rising edge into a single-cycle S or R pulse. The block guarantees the flip-flop never sees S=R=1, and it flags simultaneous commands as a conflict.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before it is accepted; legal range 1..(2^CNT_W - 1)
CNT_W, 8, width of each per-channel debounce counter

Ports:
CLK  input  1  clock; all state updates on posedge CLK
RST  input  1  synchronous, active-high reset
SET_BTN  input  1  raw asynchronous set request, active-high
CLR_BTN  input  1  raw asynchronous clear request, active-high
S  output  1  registered one-cycle set pulse to the flip-flop
R  output  1  registered one-cycle reset pulse to the flip-flop
CONFLICT  output  1  registered one-cycle flag: set and clear edges qualified on the same cycle
SET_LVL  output  1  debounced level of SET_BTN (status)
CLR_LVL  output  1  debounced level of CLR_BTN (status)

Behaviour:
- Reset (RST=1 at posedge CLK) clears to 0: both 2-flop synchroniser chains, both counters, SET_LVL, CLR_LVL, S, R, CONFLICT. Reset has priority over every other event.
- Synchroniser: each raw input passes through two flops (sync1, sync2). Raw change before edge k is visible on sync2 after edge k+1.
- Per-channel debounce FSM, states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO:
  - STABLE_LO: sync2=1 -> CHK_HI, cnt=1; otherwise hold, cnt=0.
  - CHK_HI: sync2=0 -> STABLE_LO, cnt=0 (glitch rejected). sync2=1 and cnt=DEBOUNCE_CYCLES -> STABLE_HI, LVL<=1, rise pulse. Otherwise cnt++.
  - STABLE_HI and CHK_LO mirror the above; falling acceptance sets LVL<=0 and generates no pulse.
  - With DEBOUNCE_CYCLES=1, acceptance happens on the edge after entering CHK_*.
- Counter never wraps; it is bounded by DEBOUNCE_CYCLES.
- Latency: raw input rises before edge 0 and stays stable -> LVL and the pulse are registered at edge DEBOUNCE_CYCLES+2; with the default, S is high for exactly the cycle after edge 6.
- Output pulses, registered, each at most one cycle wide:
  - set_rise only -> S=1, R=0.
  - clr_rise only -> R=1, S=0.
  - Both on the same edge -> S=0, R=0, CONFLICT=1 (no command issued).
  - Neither -> S=R=CONFLICT=0.
- Invariant: S&R==0 on every cycle, including during and after reset.
- Holding a button does not repeat the pulse; a new pulse requires an accepted fall followed by an accepted rise.
- Reset mid-operation: in-progress counts are discarded. An input held high through reset release is re-qualified from STABLE_LO and produces its pulse at edge DEBOUNCE_CYCLES+2 after the first non-reset edge.
- Opposite-channel activity does not affect a channel's counter.

Test Plan:
- Reset, then SET_BTN 0->1 held 20 cycles (D=4) -> S=1 for exactly one cycle at edge 6 after the change; SET_LVL=1 from the same edge; R=CONFLICT=0 throughout.
- SET_BTN bounce pattern 1,0,1,1,0 (one cycle each), then held high -> no S during the bounce; a single S pulse 6 edges after the final rise.
- SET_BTN and CLR_BTN rise on the same cycle, both held -> at edge 6 S=0, R=0, CONFLICT=1 for one cycle; both LVLs=1.
- CLR_BTN rises 1 cycle after SET_BTN -> S pulse at edge 6, R pulse at edge 7, CONFLICT never set, S&R never both 1.
- SET_BTN held high; RST asserted for 2 cycles at count 3, then released -> no S during reset; S pulse 6 edges after the first non-reset edge.
- SET_BTN held 50 cycles, released 10 cycles, pressed again -> exactly two S pulses; SET_LVL falls 6 edges after the release; no pulse on the fall.

Source files
------------

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner
//
// Conditions two raw, asynchronous, bouncy push-button lines into clean
// single-cycle S / R command pulses for a downstream SR flip-flop.
// Each channel is synchronised through two flops and then debounced by a
// four-state FSM. Only a qualified rising edge issues a command. When both
// channels qualify a rise on the same edge, neither command is issued and
// CONFLICT pulses instead, so S and R are never high together.
//
// Ports:
//   CLK      in   clock, all state updates on posedge
//   RST      in   synchronous active-high reset (clears every register)
//   SET_BTN  in   raw asynchronous set request, active-high
//   CLR_BTN  in   raw asynchronous clear request, active-high
//   S        out  registered one-cycle set pulse
//   R        out  registered one-cycle reset pulse
//   CONFLICT out  registered one-cycle flag, set and clear rise qualified together
//   SET_LVL  out  debounced level of SET_BTN
//   CLR_LVL  out  debounced level of CLR_BTN

module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_BTN,
    input  logic CLR_BTN,
    output logic S,
    output logic R,
    output logic CONFLICT,
    output logic SET_LVL,
    output logic CLR_LVL
);

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } db_state_t;

    // Channel 0 is the set line and channel 1 is the clear line.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       lvl;
    logic [1:0]       lvl_nxt;
    logic [1:0]       rise;
    db_state_t        state     [2];
    db_state_t        state_nxt [2];
    logic [CNT_W-1:0] cnt       [2];
    logic [CNT_W-1:0] cnt_nxt   [2];

    assign raw = {CLR_BTN, SET_BTN};

    // Stage 1: two-flop synchronisers
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stage 2: debounce FSM state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= STABLE_LO;
                cnt[ch]   <= '0;
            end
            lvl <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= state_nxt[ch];
                cnt[ch]   <= cnt_nxt[ch];
            end
            lvl <= lvl_nxt;
        end
    end

    // Next-state logic. The count is compared against the limit before
    // incrementing, so it saturates at DEBOUNCE_CYCLES and cannot wrap.
    // The rise strobe is combinational so the output register captures it
    // on the same edge the level is accepted.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_nxt[ch] = state[ch];
            cnt_nxt[ch]   = cnt[ch];
            lvl_nxt[ch]   = lvl[ch];
            rise[ch]      = 1'b0;
            case (state[ch])
                STABLE_LO: begin
                    if (sync2[ch]) begin
                        state_nxt[ch] = CHK_HI;
                        cnt_nxt[ch]   = CNT_ONE;
                    end else begin
                        cnt_nxt[ch]   = '0;
                    end
                end
                CHK_HI: begin
                    if (!sync2[ch]) begin
                        state_nxt[ch] = STABLE_LO;
                        cnt_nxt[ch]   = '0;
                    end else if (cnt[ch] == DB_LIM) begin
                        state_nxt[ch] = STABLE_HI;
                        cnt_nxt[ch]   = '0;
                        lvl_nxt[ch]   = 1'b1;
                        rise[ch]      = 1'b1;
                    end else begin
                        cnt_nxt[ch]   = cnt[ch] + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync2[ch]) begin
                        state_nxt[ch] = CHK_LO;
                        cnt_nxt[ch]   = CNT_ONE;
                    end else begin
                        cnt_nxt[ch]   = '0;
                    end
                end
                CHK_LO: begin
                    if (sync2[ch]) begin
                        state_nxt[ch] = STABLE_HI;
                        cnt_nxt[ch]   = '0;
                    end else if (cnt[ch] == DB_LIM) begin
                        // Falling acceptance updates the level only; no command.
                        state_nxt[ch] = STABLE_LO;
                        cnt_nxt[ch]   = '0;
                        lvl_nxt[ch]   = 1'b0;
                    end else begin
                        cnt_nxt[ch]   = cnt[ch] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Stage 3: command arbitration and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            S        <= 1'b0;
            R        <= 1'b0;
            CONFLICT <= 1'b0;
        end else begin
            S        <= rise[0] & ~rise[1];
            R        <= rise[1] & ~rise[0];
            CONFLICT <= rise[0] & rise[1];
        end
    end

    assign SET_LVL = lvl[0];
    assign CLR_LVL = lvl[1];

endmodule
